issue_pair_scheduler: RTL and testbench

Dual-issue pair scheduler between the fetch stage and the decode stage. It takes each fetched instruction pair (lanes A and B) and checks intra-pair hazards that the single-cycle dual-lane datapath cannot resolve. Hazard-free pairs are issued together. A hazardous pair is split: lane A issues first and the held lane-B instruction issues alone on the next cycle, with fetch stalled for that cycle.

---
 rtl/issue_pair_scheduler.sv | 115 +++++++++++
 tb/tb_issue_pair_scheduler.sv | 139 +++++++++++++
 2 files changed

// File: rtl/issue_pair_scheduler.sv
// issue_pair_scheduler: dual-issue pair splitter between fetch and decode.
// Define SCHED_PERF_EN to add the saturating split_count port.
module issue_pair_scheduler #(
   parameter int DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] NOP = 32'h00000013
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  instr_valid,
   input  logic [DATA_WIDTH-1:0] InstrA,
   input  logic [DATA_WIDTH-1:0] InstrB,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] IssueA,
   output logic [DATA_WIDTH-1:0] IssueB,
   output logic                  validA,
   output logic                  validB,
`ifdef SCHED_PERF_EN
   output logic [31:0]           split_count,
`endif
   output logic                  fetch_stall
);
   typedef enum logic {PAIR, SPLIT} state_t;

   state_t state, state_nxt;
   logic [DATA_WIDTH-1:0] hold_b, hold_nxt, a_nxt, b_nxt;
   logic va_nxt, vb_nxt, hazard;

   function automatic logic wr_rd(input logic [6:0] op);
      return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                        7'b1100111, 7'b0110111, 7'b0010111};
   endfunction
   function automatic logic rd_rs1(input logic [6:0] op);
      return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                        7'b1100011, 7'b1100111};
   endfunction
   function automatic logic rd_rs2(input logic [6:0] op);
      return op inside {7'b0110011, 7'b0100011, 7'b1100011};
   endfunction
   function automatic logic mem_op(input logic [6:0] op);
      return op inside {7'b0000011, 7'b0100011};
   endfunction
   function automatic logic ctrl_op(input logic [6:0] op);
      return op inside {7'b1100011, 7'b1101111, 7'b1100111};
   endfunction

   logic [4:0] rd_a, rd_b, rs1_b, rs2_b;
   logic [6:0] op_a, op_b;
   logic raw, waw;

   assign op_a  = InstrA[6:0];
   assign op_b  = InstrB[6:0];
   assign rd_a  = InstrA[11:7];
   assign rd_b  = InstrB[11:7];
   assign rs1_b = InstrB[19:15];
   assign rs2_b = InstrB[24:20];

   assign raw = wr_rd(op_a) && rd_a != 5'd0 &&
                ((rd_rs1(op_b) && rs1_b == rd_a) || (rd_rs2(op_b) && rs2_b == rd_a));
   assign waw = wr_rd(op_a) && wr_rd(op_b) && rd_a != 5'd0 && rd_a == rd_b;
   assign hazard = raw || waw || (mem_op(op_a) && mem_op(op_b)) || ctrl_op(op_a);

   assign fetch_stall = (state == SPLIT);

   always_comb begin
      state_nxt = PAIR;
      a_nxt     = NOP;
      b_nxt     = NOP;
      va_nxt    = 1'b0;
      vb_nxt    = 1'b0;
      hold_nxt  = hold_b;
      if (flush) begin
         hold_nxt = NOP;
      end else if (state == SPLIT) begin
         b_nxt  = hold_b;
         vb_nxt = 1'b1;
      end else if (instr_valid) begin
         a_nxt  = InstrA;
         va_nxt = 1'b1;
         if (hazard) begin
            hold_nxt  = InstrB;
            state_nxt = SPLIT;
         end else begin
            b_nxt  = InstrB;
            vb_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= PAIR;
         IssueA <= NOP;
         IssueB <= NOP;
         validA <= 1'b0;
         validB <= 1'b0;
         hold_b <= NOP;
      end else begin
         state  <= state_nxt;
         IssueA <= a_nxt;
         IssueB <= b_nxt;
         validA <= va_nxt;
         validB <= vb_nxt;
         hold_b <= hold_nxt;
      end
   end

`ifdef SCHED_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         split_count <= 32'd0;
      else if (state == PAIR && state_nxt == SPLIT && split_count != 32'hFFFFFFFF)
         split_count <= split_count + 32'd1;
   end
`endif
endmodule

// File: tb/tb_issue_pair_scheduler.sv
// tb_issue_pair_scheduler: directed vectors for the pair scheduler.
module tb_issue_pair_scheduler;
   localparam logic [31:0] NOP = 32'h00000013;

   logic clk = 1'b0, rst = 1'b1, instr_valid = 1'b0, flush = 1'b0;
   logic [31:0] InstrA = NOP, InstrB = NOP, IssueA, IssueB;
   logic validA, validB, fetch_stall;
`ifdef SCHED_PERF_EN
   logic [31:0] split_count;
`endif
   int checks = 0, failures = 0;

   issue_pair_scheduler dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .InstrA(InstrA), .InstrB(InstrB),
      .flush(flush), .IssueA(IssueA), .IssueB(IssueB), .validA(validA), .validB(validB),
`ifdef SCHED_PERF_EN
      .split_count(split_count),
`endif
      .fetch_stall(fetch_stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic f);
      instr_valid = v;
      InstrA = a;
      InstrB = b;
      flush = f;
   endtask

   task automatic outs(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic va, input logic vb, input logic st);
      check({tag, ".IssueA"}, IssueA, a);
      check({tag, ".IssueB"}, IssueB, b);
      check({tag, ".validA"}, {31'd0, validA}, {31'd0, va});
      check({tag, ".validB"}, {31'd0, validB}, {31'd0, vb});
      check({tag, ".stall"}, {31'd0, fetch_stall}, {31'd0, st});
   endtask

   task automatic cnt(input string tag, input logic [31:0] exp);
`ifdef SCHED_PERF_EN
      check(tag, split_count, exp);
`endif
   endtask

   initial begin
      #12;
      outs("reset", NOP, NOP, 0, 0, 0);
      cnt("reset.cnt", 0);
      rst = 1'b0;
      #1;
      // independent pair
      drive(1, 32'h00100293, 32'h00200393, 0);
      tick();
      outs("indep", 32'h00100293, 32'h00200393, 1, 1, 0);
      // RAW split; a different pair during the stall must be ignored
      drive(1, 32'h00100293, 32'h00528333, 0);
      tick();
      outs("raw1", 32'h00100293, NOP, 1, 0, 1);
      cnt("raw.cnt", 1);
      drive(1, 32'h00100013, 32'h00200393, 0);
      tick();
      outs("raw2", NOP, 32'h00528333, 0, 1, 0);
      // x0 exemption
      drive(1, 32'h00100013, 32'h00000333, 0);
      tick();
      outs("x0", 32'h00100013, 32'h00000333, 1, 1, 0);
      // MEM split
      drive(1, 32'h00002403, 32'h00902223, 0);
      tick();
      outs("mem1", 32'h00002403, NOP, 1, 0, 1);
      drive(0, NOP, NOP, 0);
      tick();
      outs("mem2", NOP, 32'h00902223, 0, 1, 0);
      // WAW split
      drive(1, 32'h00100293, 32'h00200293, 0);
      tick();
      outs("waw1", 32'h00100293, NOP, 1, 0, 1);
      drive(0, NOP, NOP, 0);
      tick();
      outs("waw2", NOP, 32'h00200293, 0, 1, 0);
      // CTRL split: jal x0 in lane A
      drive(1, 32'h0000006f, 32'h00200393, 0);
      tick();
      outs("ctrl1", 32'h0000006f, NOP, 1, 0, 1);
      cnt("ctrl.cnt", 4);
      drive(0, NOP, NOP, 0);
      tick();
      outs("ctrl2", NOP, 32'h00200393, 0, 1, 0);
      // idle
      tick();
      outs("idle", NOP, NOP, 0, 0, 0);
      // flush during SPLIT
      drive(1, 32'h00100293, 32'h00528333, 0);
      tick();
      outs("fl1", 32'h00100293, NOP, 1, 0, 1);
      drive(1, 32'h00100293, 32'h00200393, 1);
      tick();
      outs("fl2", NOP, NOP, 0, 0, 0);
      drive(0, NOP, NOP, 0);
      tick();
      outs("fl3", NOP, NOP, 0, 0, 0);
      cnt("fl.cnt", 5);
      // flush beats a hazardous valid pair in PAIR
      drive(1, 32'h00100293, 32'h00528333, 1);
      tick();
      outs("flp", NOP, NOP, 0, 0, 0);
      cnt("flp.cnt", 5);
      // async reset mid-SPLIT
      drive(1, 32'h00100293, 32'h00528333, 0);
      tick();
      outs("rs1", 32'h00100293, NOP, 1, 0, 1);
      cnt("rs1.cnt", 6);
      rst = 1'b1;
      #1;
      outs("rs2", NOP, NOP, 0, 0, 0);
      cnt("rs2.cnt", 0);
      #1;
      rst = 1'b0;
      drive(1, 32'h00100293, 32'h00200393, 0);
      tick();
      outs("post", 32'h00100293, 32'h00200393, 1, 1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
